audio_playback_scheduler: RTL and testbench

AUDIO_PLAYBACK_SCHEDULER -- requirements
Module: audio_playback_scheduler

---
 rtl/audio_playback_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_audio_playback_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_playback_scheduler.sv
// -----------------------------------------------------------------------------
// audio_playback_scheduler
// Purpose: sequences playback of one audio track from the HPS wav FIFO into the
// DAC FIFOs. It primes the wav FIFO before playing, rebuffers on sustained
// underrun, supports pause/resume/stop, and drains the DAC path after the last
// sample before reporting completion.
//
// Ports:
//   audio_clk       in   sole clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   cmd_start       in   one-cycle start/resume request
//   cmd_pause       in   one-cycle pause request
//   cmd_stop        in   one-cycle stop request
//   track_len[31:0] in   track length in stereo samples (latched on start)
//   wav_level       in   wav FIFO fill level (LEVEL_W bits)
//   wav_valid       in   wav FIFO has a sample
//   dac_ready       in   both DAC FIFOs ready
//   play_out        out  mixer play enable (state == PLAY)
//   state_out[2:0]  out  current state encoding
//   sample_count    out  samples transferred in current track
//   done_pulse      out  one-cycle pulse on normal completion
//   underrun_count  out  total PLAY underrun cycles (saturating)
//
// Configuration macro: AUDIO_UNDERRUN_STATS_EN enables the underrun_count
// statistics counter; when undefined underrun_count is tied to zero.
// -----------------------------------------------------------------------------
module audio_playback_scheduler #(
  parameter int unsigned PRIME_LEVEL    = 64,
  parameter int unsigned UNDERRUN_LIMIT = 8,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned LEVEL_W        = 8
) (
  input  logic               audio_clk,
  input  logic               reset_n,
  input  logic               cmd_start,
  input  logic               cmd_pause,
  input  logic               cmd_stop,
  input  logic [31:0]        track_len,
  input  logic [LEVEL_W-1:0] wav_level,
  input  logic               wav_valid,
  input  logic               dac_ready,
  output logic               play_out,
  output logic [2:0]         state_out,
  output logic [31:0]        sample_count,
  output logic               done_pulse,
  output logic [15:0]        underrun_count
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned STAT_W = 16;
  // Streak counter must be able to hold UNDERRUN_LIMIT itself for the compare.
  localparam int unsigned UR_W   = (UNDERRUN_LIMIT < 2) ? 1 : $clog2(UNDERRUN_LIMIT + 1);
  // Drain counter only needs to reach DRAIN_CYCLES-1.
  localparam int unsigned DR_W   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  localparam logic [LEVEL_W:0] PRIME_LVL  = (LEVEL_W + 1)'(PRIME_LEVEL);
  localparam logic [UR_W-1:0]  UR_LIMIT   = UR_W'(UNDERRUN_LIMIT);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_len;
  logic [UR_W-1:0]    r_urun;
  logic [DR_W-1:0]    r_drain;
  logic               r_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CNT_W-1:0]   w_len_nxt;
  logic [UR_W-1:0]    w_urun_nxt;
  logic [DR_W-1:0]    w_drain_nxt;
  logic               w_done_nxt;

  logic               w_stop;
  logic               w_pause;
  logic               w_start;
  logic               w_fire;
  logic               w_under;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [UR_W-1:0]    w_urun_inc;
  logic               w_last;
  logic               w_urun_hit;
  logic               w_level_ok;

  // Command priority: stop masks pause and start, pause masks start.
  assign w_stop     = cmd_stop;
  assign w_pause    = cmd_pause & ~cmd_stop;
  assign w_start    = cmd_start & ~cmd_pause & ~cmd_stop;

  assign play_out   = (r_state == S_PLAY);
  assign state_out  = r_state;
  assign sample_count = r_count;
  assign done_pulse = r_done;

  assign w_fire     = play_out & wav_valid & dac_ready;
  assign w_under    = play_out & dac_ready & ~wav_valid;
  assign w_cnt_inc  = r_count + CNT_W'(1);
  assign w_urun_inc = r_urun + UR_W'(1);
  assign w_last     = w_fire && (w_cnt_inc == r_len);
  assign w_urun_hit = w_under && (w_urun_inc == UR_LIMIT);
  assign w_level_ok = ({1'b0, wav_level} >= PRIME_LVL);

  // State and datapath registers.
  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_urun  <= '0;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_len   <= w_len_nxt;
      r_urun  <= w_urun_nxt;
      r_drain <= w_drain_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_len_nxt   = r_len;
    w_urun_nxt  = '0;
    w_drain_nxt = '0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start && (track_len != '0)) begin
          w_state_nxt = S_PRIME;
          w_len_nxt   = track_len;
          w_count_nxt = '0;
        end
      end

      S_PRIME: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_pause) begin
          w_state_nxt = S_PAUSE;
        end else if (w_level_ok) begin
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        // A fire is always counted, even when a command leaves PLAY.
        if (w_fire) begin
          w_count_nxt = w_cnt_inc;
        end
        if (w_fire) begin
          w_urun_nxt = '0;
        end else if (w_under) begin
          w_urun_nxt = w_urun_inc;
        end else begin
          w_urun_nxt = r_urun;
        end
        // Completion outranks pause so a finished track never parks in PAUSE.
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else if (w_pause) begin
          w_state_nxt = S_PAUSE;
        end else if (w_urun_hit) begin
          w_state_nxt = S_PRIME;
        end
        // Streak is only meaningful while playing.
        if (w_state_nxt != S_PLAY) begin
          w_urun_nxt = '0;
        end
      end

      S_PAUSE: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_start) begin
          w_state_nxt = S_PRIME;
        end
      end

      S_DRAIN: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_drain == DRAIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_drain_nxt = r_drain + DR_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef AUDIO_UNDERRUN_STATS_EN
  logic [STAT_W-1:0] r_ucnt;

  // Lifetime underrun statistic, saturating, cleared only by reset.
  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ucnt <= '0;
    end else if (w_under && (r_ucnt != {STAT_W{1'b1}})) begin
      r_ucnt <= r_ucnt + STAT_W'(1);
    end
  end

  assign underrun_count = r_ucnt;
`else
  assign underrun_count = STAT_W'(0);
`endif

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// -----------------------------------------------------------------------------
// tb_audio_playback_scheduler
// Purpose: self-checking bench for audio_playback_scheduler. Directed scenarios
// for run, prime, underrun, pause, priority and reset, followed by randomized
// traffic, all compared each cycle against a behavioural player model.
// -----------------------------------------------------------------------------
module tb_audio_playback_scheduler;

  localparam int PRIME_LEVEL    = 64;
  localparam int UNDERRUN_LIMIT = 8;
  localparam int DRAIN_CYCLES   = 16;
  localparam int LEVEL_W        = 8;

  localparam int ST_IDLE  = 0;
  localparam int ST_PRIME = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_PAUSE = 3;
  localparam int ST_DRAIN = 4;

  logic               audio_clk = 1'b0;
  logic               reset_n;
  logic               cmd_start;
  logic               cmd_pause;
  logic               cmd_stop;
  logic [31:0]        track_len;
  logic [LEVEL_W-1:0] wav_level;
  logic               wav_valid;
  logic               dac_ready;
  logic               play_out;
  logic [2:0]         state_out;
  logic [31:0]        sample_count;
  logic               done_pulse;
  logic [15:0]        underrun_count;

  audio_playback_scheduler #(
    .PRIME_LEVEL    (PRIME_LEVEL),
    .UNDERRUN_LIMIT (UNDERRUN_LIMIT),
    .DRAIN_CYCLES   (DRAIN_CYCLES),
    .LEVEL_W        (LEVEL_W)
  ) dut (
    .audio_clk      (audio_clk),
    .reset_n        (reset_n),
    .cmd_start      (cmd_start),
    .cmd_pause      (cmd_pause),
    .cmd_stop       (cmd_stop),
    .track_len      (track_len),
    .wav_level      (wav_level),
    .wav_valid      (wav_valid),
    .dac_ready      (dac_ready),
    .play_out       (play_out),
    .state_out      (state_out),
    .sample_count   (sample_count),
    .done_pulse     (done_pulse),
    .underrun_count (underrun_count)
  );

  always #5 audio_clk = ~audio_clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_done = 0;

  // Behavioural player model
  int          m_state;
  logic [31:0] m_cnt;
  logic [31:0] m_len;
  int          m_streak;
  int          m_drained;
  bit          m_done;
  int          m_ustat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_ustat();
`ifdef AUDIO_UNDERRUN_STATS_EN
    return 16'(m_ustat);
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_cnt = 0; m_len = 0; m_streak = 0;
    m_drained = 0; m_done = 0; m_ustat = 0;
  endtask

  // One clock of the player as seen from the outside.
  task automatic model_step(input bit st, input bit pa, input bit sp, input logic [31:0] len,
                            input int lvl, input bit v, input bit r);
    bit stop_c  = sp;
    bit pause_c = pa && !sp;
    bit start_c = st && !pa && !sp;
    bit playing = (m_state == ST_PLAY);
    bit fire    = playing && v && r;
    bit under   = playing && r && !v;
    m_done = 0;
    if (fire) m_cnt = m_cnt + 1;
    if (under && m_ustat < 65535) m_ustat++;
    if (fire) m_streak = 0;
    else if (under) m_streak++;
    case (m_state)
      ST_IDLE:
        if (start_c && len != 0) begin
          m_len = len; m_cnt = 0; m_state = ST_PRIME;
        end
      ST_PRIME:
        if (stop_c) m_state = ST_IDLE;
        else if (pause_c) m_state = ST_PAUSE;
        else if (lvl >= PRIME_LEVEL) m_state = ST_PLAY;
      ST_PLAY:
        if (stop_c) m_state = ST_IDLE;
        else if (fire && m_cnt == m_len) begin m_state = ST_DRAIN; m_drained = 0; end
        else if (pause_c) m_state = ST_PAUSE;
        else if (m_streak >= UNDERRUN_LIMIT) m_state = ST_PRIME;
      ST_PAUSE:
        if (stop_c) m_state = ST_IDLE;
        else if (start_c) m_state = ST_PRIME;
      ST_DRAIN:
        if (stop_c) m_state = ST_IDLE;
        else begin
          m_drained++;
          if (m_drained == DRAIN_CYCLES) begin m_state = ST_IDLE; m_done = 1; end
        end
      default: m_state = ST_IDLE;
    endcase
    if (m_state != ST_PLAY) m_streak = 0;
  endtask

  task automatic compare_all();
    check("state", 32'(state_out), 32'(m_state));
    check("play_out", 32'(play_out), 32'(m_state == ST_PLAY));
    check("sample_count", sample_count, m_cnt);
    check("done_pulse", 32'(done_pulse), 32'(m_done));
    check("underrun_count", 32'(underrun_count), 32'(exp_ustat()));
    obs_done += int'(done_pulse);
  endtask

  // Drive one cycle of inputs at the falling edge, advance, and compare.
  task automatic cycle(input bit st, input bit pa, input bit sp, input logic [31:0] len,
                       input int lvl, input bit v, input bit r);
    cmd_start = st; cmd_pause = pa; cmd_stop = sp; track_len = len;
    wav_level = LEVEL_W'(lvl); wav_valid = v; dac_ready = r;
    @(posedge audio_clk);
    model_step(st, pa, sp, len, lvl, v, r);
    @(negedge audio_clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input int lvl, input bit v, input bit r);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, lvl, v, r);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_state", 32'(state_out), 32'(ST_IDLE));
    check("rst_play", 32'(play_out), 32'd0);
    check("rst_count", sample_count, 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_ustat", 32'(underrun_count), 32'd0);
    @(negedge audio_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int d0;
    bit starve;
    reset_n = 1'b0;
    cmd_start = 0; cmd_pause = 0; cmd_stop = 0; track_len = 0;
    wav_level = 0; wav_valid = 0; dac_ready = 0;
    model_reset();
    @(negedge audio_clk);
    apply_reset();

    // Zero-length start is ignored.
    cycle(1, 0, 0, 32'd0, 64, 1, 1);
    check("zero_len_idle", 32'(state_out), 32'(ST_IDLE));

    // Full run of a 4-sample track.
    d0 = obs_done;
    cycle(1, 0, 0, 32'd4, 64, 1, 1);
    check("run_prime", 32'(state_out), 32'(ST_PRIME));
    cycle(0, 0, 0, 32'd0, 64, 1, 1);
    check("run_play", 32'(state_out), 32'(ST_PLAY));
    idle_cycles(4, 64, 1, 1);
    check("run_drain", 32'(state_out), 32'(ST_DRAIN));
    idle_cycles(DRAIN_CYCLES, 64, 1, 1);
    check("run_done_now", 32'(done_pulse), 32'd1);
    idle_cycles(3, 64, 1, 1);
    check("run_done_once", 32'(obs_done - d0), 32'd1);
    check("run_count", sample_count, 32'd4);

    // Prime holds below threshold, enters PLAY once level reaches it.
    cycle(1, 0, 0, 32'd50, 63, 1, 1);
    idle_cycles(10, 63, 1, 1);
    check("prime_hold", 32'(state_out), 32'(ST_PRIME));
    check("prime_noplay", 32'(play_out), 32'd0);
    cycle(0, 0, 0, 32'd0, 64, 1, 1);
    check("prime_go", 32'(state_out), 32'(ST_PLAY));

    // Underrun streak forces a rebuffer.
    idle_cycles(UNDERRUN_LIMIT - 1, 64, 0, 1);
    check("urun_still_play", 32'(state_out), 32'(ST_PLAY));
    cycle(0, 0, 0, 32'd0, 64, 0, 1);
    check("urun_prime", 32'(state_out), 32'(ST_PRIME));
    check("urun_play_off", 32'(play_out), 32'd0);
`ifdef AUDIO_UNDERRUN_STATS_EN
    check("urun_stat", 32'(underrun_count), 32'd8);
`else
    check("urun_stat", 32'(underrun_count), 32'd0);
`endif
    cycle(0, 0, 1, 32'd0, 64, 1, 1);

    // Pause after 3 samples, then resume.
    cycle(1, 0, 0, 32'd20, 64, 1, 1);
    cycle(0, 0, 0, 32'd0, 64, 1, 1);
    idle_cycles(2, 64, 1, 1);
    cycle(0, 1, 0, 32'd0, 64, 1, 1);
    check("pause_state", 32'(state_out), 32'(ST_PAUSE));
    check("pause_count", sample_count, 32'd3);
    idle_cycles(3, 64, 1, 1);
    cycle(1, 0, 0, 32'd0, 64, 1, 1);
    check("resume_prime", 32'(state_out), 32'(ST_PRIME));
    cycle(0, 0, 0, 32'd0, 64, 1, 1);
    cycle(0, 0, 0, 32'd0, 64, 1, 1);
    check("resume_count", sample_count, 32'd4);

    // All three commands in PLAY: stop wins, fire still counted.
    d0 = obs_done;
    cycle(1, 1, 1, 32'd0, 64, 1, 1);
    check("prio_idle", 32'(state_out), 32'(ST_IDLE));
    check("prio_count", sample_count, 32'd5);
    idle_cycles(4, 64, 1, 1);
    check("prio_held", sample_count, 32'd5);
    check("prio_nodone", 32'(obs_done - d0), 32'd0);

    // Reset in the middle of DRAIN.
    cycle(1, 0, 0, 32'd2, 64, 1, 1);
    idle_cycles(3, 64, 1, 1);
    idle_cycles(5, 64, 1, 1);
    check("rst_in_drain", 32'(state_out), 32'(ST_DRAIN));
    d0 = obs_done;
    apply_reset();
    idle_cycles(DRAIN_CYCLES + 4, 64, 1, 1);
    check("rst_nodone", 32'(obs_done - d0), 32'd0);

    // Randomized traffic.
    starve = 0;
    for (int i = 0; i < 4000; i++) begin
      bit st, pa, sp, v, r;
      int lvl;
      logic [31:0] len;
      st  = ($urandom_range(0, 7) == 0);
      pa  = ($urandom_range(0, 24) == 0);
      sp  = ($urandom_range(0, 49) == 0);
      len = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 100)) : 32'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0, 1: lvl = $urandom_range(64, 255);
        2:    lvl = 63;
        default: lvl = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 29) == 0) starve = !starve;
      v = starve ? 1'b0 : ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 19) < 17);
      cycle(st, pa, sp, len, lvl, v, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
